// File: rtl/half16_normalize_round.sv
// Binary16 normalize / round-to-nearest-even / pack stage for the half-precision adder.
// Optional macro HALF16_FTZ_EN flushes subnormal results to signed zero.
module half16_normalize_round (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        IN_SIGN,
    input  logic [5:0]  IN_EXP,
    input  logic [13:0] IN_MANT,
    input  logic        IN_STICKY,
    input  logic        IN_EXC,
    input  logic [15:0] IN_Q,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [15:0] OUT_Q,
    output logic        OUT_EXC,
    output logic        OUT_OVF,
    output logic        OUT_UNF,
    output logic        OUT_INX
);

    typedef enum logic [1:0] {ST_IDLE, ST_NORM, ST_ROUND, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [6:0]  exp_q, exp_d;
    logic [12:0] mant_q, mant_d;
    logic        sticky_q, sticky_d;
    logic        byp_q, byp_d;
    logic        byp_exc_q, byp_exc_d;
    logic [15:0] byp_word_q, byp_word_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_q_q, out_q_d;
    logic        out_exc_q, out_exc_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        inx_q, inx_d;

    logic [6:0]  exp_eff;
    logic        rnd_inc;
    logic [11:0] rnd_sum;
    logic [6:0]  exp_r;
    logic        hidden_r;
    logic [4:0]  exp_field;
    logic [9:0]  frac_r;
    logic        rnd_inx;
    logic        rnd_tiny;

    always_comb begin
        exp_eff   = (IN_EXP == 6'd0) ? 7'd1 : {1'b0, IN_EXP};
        rnd_inc   = mant_q[1] & (mant_q[0] | sticky_q | mant_q[2]);
        rnd_sum   = {1'b0, mant_q[12:2]} + {11'd0, rnd_inc};
        exp_r     = exp_q + {6'd0, rnd_sum[11]};
        hidden_r  = rnd_sum[11] | rnd_sum[10];
        exp_field = hidden_r ? exp_r[4:0] : 5'd0;
        frac_r    = rnd_sum[9:0];
        rnd_inx   = mant_q[1] | mant_q[0] | sticky_q;
        rnd_tiny  = ~mant_q[12];
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        sticky_d    = sticky_q;
        byp_d       = byp_q;
        byp_exc_d   = byp_exc_q;
        byp_word_d  = byp_word_q;
        out_valid_d = out_valid_q;
        out_q_d     = out_q_q;
        out_exc_d   = out_exc_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        inx_d       = inx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    sign_d = IN_SIGN;
                    // Bypass and exact-zero words wait one cycle in ROUND so their latency matches the spec'd t+1.
                    if (IN_EXC) begin
                        byp_d      = 1'b1;
                        byp_exc_d  = 1'b1;
                        byp_word_d = IN_Q;
                        state_d    = ST_ROUND;
                    end else if (IN_MANT == 14'd0 && !IN_STICKY) begin
                        byp_d      = 1'b1;
                        byp_exc_d  = 1'b0;
                        byp_word_d = {IN_SIGN, 15'd0};
                        state_d    = ST_ROUND;
                    end else begin
                        byp_d = 1'b0;
                        if (IN_MANT[13]) begin
                            mant_d   = IN_MANT[13:1];
                            sticky_d = IN_STICKY | IN_MANT[0];
                            exp_d    = exp_eff + 7'd1;
                        end else begin
                            mant_d   = IN_MANT[12:0];
                            sticky_d = IN_STICKY;
                            exp_d    = exp_eff;
                        end
                        state_d = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                if (mant_q[12] || exp_q == 7'd1) begin
                    state_d = ST_ROUND;
                end else begin
                    mant_d = {mant_q[11:0], 1'b0};
                    exp_d  = exp_q - 7'd1;
                end
            end
            ST_ROUND: begin
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
                if (byp_q) begin
                    out_q_d   = byp_word_q;
                    out_exc_d = byp_exc_q;
                    ovf_d     = 1'b0;
                    unf_d     = 1'b0;
                    inx_d     = 1'b0;
                end else begin
                    out_exc_d = 1'b0;
                    unf_d     = rnd_tiny & rnd_inx;
                    inx_d     = rnd_inx;
                    if (exp_r >= 7'd31) begin
                        out_q_d = {sign_q, 5'h1F, 10'h000};
                        ovf_d   = 1'b1;
                        inx_d   = 1'b1;
                    end else begin
                        out_q_d = {sign_q, exp_field, frac_r};
                        ovf_d   = 1'b0;
`ifdef HALF16_FTZ_EN
                        if (exp_field == 5'd0 && frac_r != 10'd0) begin
                            out_q_d = {sign_q, 15'd0};
                            unf_d   = 1'b1;
                            inx_d   = 1'b1;
                        end
`endif
                    end
                end
            end
            ST_DONE: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            sticky_q    <= 1'b0;
            byp_q       <= 1'b0;
            byp_exc_q   <= 1'b0;
            byp_word_q  <= '0;
            out_valid_q <= 1'b0;
            out_q_q     <= '0;
            out_exc_q   <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            sticky_q    <= sticky_d;
            byp_q       <= byp_d;
            byp_exc_q   <= byp_exc_d;
            byp_word_q  <= byp_word_d;
            out_valid_q <= out_valid_d;
            out_q_q     <= out_q_d;
            out_exc_q   <= out_exc_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inx_q       <= inx_d;
        end
    end

    assign IN_READY  = (state_q == ST_IDLE);
    assign OUT_VALID = out_valid_q;
    assign OUT_Q     = out_q_q;
    assign OUT_EXC   = out_exc_q;
    assign OUT_OVF   = ovf_q;
    assign OUT_UNF   = unf_q;
    assign OUT_INX   = inx_q;

endmodule

// File: tb/tb_half16_normalize_round.sv
// Directed bench for half16_normalize_round: results, flags, latency, backpressure, reset abort.
module tb_half16_normalize_round;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic        IN_SIGN = 1'b0;
    logic [5:0]  IN_EXP = '0;
    logic [13:0] IN_MANT = '0;
    logic        IN_STICKY = 1'b0;
    logic        IN_EXC = 1'b0;
    logic [15:0] IN_Q = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [15:0] OUT_Q;
    logic        OUT_EXC, OUT_OVF, OUT_UNF, OUT_INX;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    half16_normalize_round dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_SIGN(IN_SIGN), .IN_EXP(IN_EXP), .IN_MANT(IN_MANT), .IN_STICKY(IN_STICKY),
        .IN_EXC(IN_EXC), .IN_Q(IN_Q), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_Q(OUT_Q), .OUT_EXC(OUT_EXC), .OUT_OVF(OUT_OVF), .OUT_UNF(OUT_UNF),
        .OUT_INX(OUT_INX)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Flags are packed {EXC, OVF, UNF, INX}.
    task automatic run_op(input string name, input logic s, input logic [5:0] e,
                          input logic [13:0] m, input logic st, input logic exc,
                          input logic [15:0] q, input logic [15:0] exp_q,
                          input logic [3:0] exp_fl, input int exp_lat, input int stall);
        int lat;
        @(negedge CLK);
        check({name, ".ready"}, 32'(IN_READY), 32'd1);
        IN_SIGN = s; IN_EXP = e; IN_MANT = m; IN_STICKY = st; IN_EXC = exc; IN_Q = q;
        IN_VALID = 1'b1;
        OUT_READY = 1'b0;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        lat = 0;
        while (!OUT_VALID && lat < 40) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check({name, ".lat"}, 32'(lat), 32'(exp_lat));
        check({name, ".q"}, 32'(OUT_Q), 32'(exp_q));
        check({name, ".flags"}, 32'({OUT_EXC, OUT_OVF, OUT_UNF, OUT_INX}), 32'(exp_fl));
        for (int i = 0; i < stall; i++) begin
            @(posedge CLK);
            #1;
            check({name, ".stall_q"}, 32'(OUT_Q), 32'(exp_q));
            check({name, ".stall_valid"}, 32'(OUT_VALID), 32'd1);
            check({name, ".stall_ready"}, 32'(IN_READY), 32'd0);
        end
        @(negedge CLK);
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        check({name, ".drop_valid"}, 32'(OUT_VALID), 32'd0);
        check({name, ".back_idle"}, 32'(IN_READY), 32'd1);
    endtask

    initial begin
        #12;
        check("rst.valid", 32'(OUT_VALID), 32'd0);
        check("rst.q", 32'(OUT_Q), 32'd0);
        check("rst.flags", 32'({OUT_EXC, OUT_OVF, OUT_UNF, OUT_INX}), 32'd0);
        check("rst.ready", 32'(IN_READY), 32'd1);
        @(negedge CLK);
        RST_N = 1'b1;

        run_op("bypass",  1'b0, 6'd0,  14'b00_0000000000_00, 1'b0, 1'b1, 16'h7E00, 16'h7E00, 4'b1000, 1, 0);
        run_op("zero",    1'b1, 6'd10, 14'b00_0000000000_00, 1'b0, 1'b0, 16'h1234, 16'h8000, 4'b0000, 1, 0);
        run_op("carry",   1'b0, 6'd15, 14'b11_0000000000_00, 1'b0, 1'b0, 16'h0,    16'h4200, 4'b0000, 2, 0);
        run_op("cancel",  1'b0, 6'd15, 14'b00_0000000001_00, 1'b0, 1'b0, 16'h0,    16'h1400, 4'b0000, 12, 0);
        run_op("tie_odd", 1'b0, 6'd15, 14'b01_0000000001_10, 1'b0, 1'b0, 16'h0,    16'h3C02, 4'b0001, 2, 0);
        run_op("tie_even",1'b0, 6'd15, 14'b01_0000000000_10, 1'b0, 1'b0, 16'h0,    16'h3C00, 4'b0001, 2, 0);
        run_op("sticky_up",1'b0,6'd15, 14'b01_0000000000_10, 1'b1, 1'b0, 16'h0,    16'h3C01, 4'b0001, 2, 0);
        run_op("ovf",     1'b0, 6'd30, 14'b01_1111111111_11, 1'b0, 1'b0, 16'h0,    16'h7C00, 4'b0101, 2, 0);
        run_op("sub_to_norm", 1'b0, 6'd1, 14'b00_1111111111_11, 1'b0, 1'b0, 16'h0, 16'h0400, 4'b0011, 2, 0);
`ifdef HALF16_FTZ_EN
        run_op("subnorm", 1'b0, 6'd1,  14'b00_1000000000_00, 1'b0, 1'b0, 16'h0,    16'h0000, 4'b0011, 2, 3);
        run_op("exp0",    1'b1, 6'd0,  14'b00_0000000001_00, 1'b0, 1'b0, 16'h0,    16'h8000, 4'b0011, 2, 0);
`else
        run_op("subnorm", 1'b0, 6'd1,  14'b00_1000000000_00, 1'b0, 1'b0, 16'h0,    16'h0200, 4'b0000, 2, 3);
        run_op("exp0",    1'b1, 6'd0,  14'b00_0000000001_00, 1'b0, 1'b0, 16'h0,    16'h8001, 4'b0000, 2, 0);
`endif

        // Abort an in-flight normalization with reset.
        @(negedge CLK);
        IN_SIGN = 1'b0; IN_EXP = 6'd15; IN_MANT = 14'b00_0000000001_00; IN_STICKY = 1'b0;
        IN_EXC = 1'b0; IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("abort.valid", 32'(OUT_VALID), 32'd0);
        check("abort.q", 32'(OUT_Q), 32'd0);
        check("abort.ready", 32'(IN_READY), 32'd1);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (14) @(posedge CLK);
        #1;
        check("abort.no_result", 32'(OUT_VALID), 32'd0);
        run_op("post_abort", 1'b1, 6'd15, 14'b11_0000000000_00, 1'b0, 1'b0, 16'h0, 16'hC200, 4'b0000, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/half16_normalize_round.md
# half16_normalize_round

Output-side companion to the half-precision special-case classifier. It takes the unnormalized sum/difference produced by the binary16 adder datapath, normalizes it one bit per cycle, applies round-to-nearest-even and packs an IEEE 754 binary16 word with status flags. When the classifier has already resolved a special case, that word is forwarded unchanged. It sits at the tail of the adder, between the mantissa add/subtract stage and the result register file, behind a valid/ready handshake on both sides.

## Interface
- No parameters; the format is fixed to binary16 (1/5/10).
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  input word valid.
- IN_READY  out  1  block can accept; high only in IDLE.
- IN_SIGN  in  1  result sign.
- IN_EXP  in  6  biased exponent, bias 15; 0 is treated as 1 (subnormal scale).
- IN_MANT  in  14  {carry, hidden, frac[9:0], guard, round}.
- IN_STICKY  in  1  OR of all bits shifted out below round.
- IN_EXC  in  1  special case already resolved by the classifier.
- IN_Q  in  16  classifier result; used only when IN_EXC=1.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts the result.
- OUT_Q  out  16  packed binary16 result.
- OUT_EXC  out  1  result came from the bypass path.
- OUT_OVF / OUT_UNF / OUT_INX  out  1 each  overflow, underflow and inexact flags.

## Operation
- States: IDLE, NORM, ROUND, DONE.
- Reset: state IDLE. OUT_VALID=0, OUT_Q=0, all flags 0, IN_READY=1.
- Accept happens on IN_VALID && IN_READY. Capture rules, in priority order:
  - IN_EXC=1: OUT_Q=IN_Q, OUT_EXC=1, other flags 0, go to DONE.
  - IN_MANT=0 and IN_STICKY=0: OUT_Q={IN_SIGN,15'b0}, flags 0, go to DONE.
  - Otherwise: if the carry bit is set, shift right 1, OR the LSB into sticky, exp+1. Go to NORM.
- NORM: if hidden=1 or exp=1, go to ROUND with no shift. Otherwise shift left 1 (zero in), exp-1, stay in NORM.
- ROUND:
  - L=mant[2], G=mant[1], R=mant[0], S=sticky.
  - Increment when G && (R || S || L).
  - If mant[12:2]+inc carries out, frac=0 and exp+1.
  - A subnormal that rounds into the hidden bit becomes exp field 1.
  - Exp field is 0 if hidden=0 after rounding, else exp.
  - If exp ≥ 31: OUT_Q={S,5'h1F,10'h0}, OVF=1, INX=1.
  - INX = G|R|S.
  - UNF = tiny (exp field 0 before rounding, nonzero value) && INX.
  - Go to DONE.
- DONE: OUT_VALID=1, outputs held stable. On OUT_READY, go to IDLE and drop OUT_VALID next cycle.
- IN_READY=0 in NORM, ROUND and DONE. There is no overlap: one operation is in flight at a time.
- Reset asserted mid-operation aborts the operation immediately and discards it. Outputs return to their reset values.

## Timing
- Edge counts are measured from the accept edge t.
- Bypass or zero: OUT_VALID high after edge t+1.
- Normal path with k left shifts (0 ≤ k ≤ 11): NORM lasts k+1 cycles and ROUND lasts 1 cycle. OUT_VALID is high after edge t+k+2.
- A carry right-shift costs no extra cycle.
- Next accept is no earlier than the cycle after OUT_VALID&&OUT_READY.
- Output registers update only on entry to DONE.

## Configuration
- HALF16_FTZ_EN defined: any result with exp field 0 and nonzero frac becomes {sign,15'b0}, with UNF=1 and INX=1. The check is applied after rounding.
- HALF16_FTZ_EN undefined: gradual underflow; subnormals are emitted as computed above.

## Test plan
- Bypass: IN_EXC=1, IN_Q=16'h7E00 -> OUT_Q=16'h7E00, OUT_EXC=1, other flags 0, OUT_VALID after t+1.
- Carry: IN_EXP=15, IN_MANT=14'b11_0000000000_00 -> OUT_Q=16'h4200, no flags, OUT_VALID after t+2.
- Cancellation: IN_EXP=15, IN_MANT=14'b00_0000000001_00 -> OUT_Q=16'h1400, no flags, OUT_VALID after t+12.
- Tie-to-even, IN_EXP=15, INX=1 in both cases:
  - IN_MANT=14'b01_0000000001_10, STICKY=0 -> 16'h3C02.
  - IN_MANT=14'b01_0000000000_10 -> 16'h3C00.
- Overflow: IN_EXP=30, IN_MANT=14'b01_1111111111_11 -> 16'h7C00, OVF=1, INX=1.
- Subnormal and backpressure: IN_EXP=1, IN_MANT=14'b00_1000000000_00, OUT_READY low for 3 cycles.
  - Without FTZ: 16'h0200, UNF=0.
  - With FTZ: 16'h0000, UNF=1.
  - OUT_Q stable and IN_READY=0 while stalled.
